// File: rtl/angle_disp_pkg.sv
// Shared definitions for the angle display path: converter state encoding,
// digit geometry and the sign nibble codes understood by the display driver.
package angle_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  localparam int BCD_DIGITS = 5;
  localparam int CONV_ITERS = 16;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int BIN_W      = 16;

  localparam logic [3:0] DEF_SIGN_NEG   = 4'hA;
  localparam logic [3:0] DEF_SIGN_BLANK = 4'hF;

  // Magnitude of a 16-bit two's-complement value; -32768 maps to 0x8000.
  function automatic logic [BIN_W-1:0] abs16(input logic [BIN_W-1:0] v);
    return v[BIN_W-1] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/angle_bcd_conv_if.sv
// Sample-in / display-word-out bundle between the filter, converter and display driver.
interface angle_bcd_conv_if;
  logic [15:0] angle_in;
  logic        angle_vld_in;
  logic [23:0] data_out;
  logic        data_vld_out;
  logic        busy_out;

  modport master (
    output angle_in, angle_vld_in,
    input  data_out, data_vld_out, busy_out
  );

  modport slave (
    input  angle_in, angle_vld_in,
    output data_out, data_vld_out, busy_out
  );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// the concatenated {bcd, bin} word left by one bit.
module bcd_dabble_step
  import angle_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_in,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic [BIN_W-1:0] bin_out
);

  logic [BCD_W-1:0] bcd_adj;

  generate
    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      assign bcd_adj[gi*4 +: 4] = (bcd_in[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_in[gi*4 +: 4] + 4'd3) : bcd_in[gi*4 +: 4];
    end
  endgenerate

  assign {bcd_out, bin_out} = {bcd_adj[BCD_W-2:0], bin_in, 1'b0};

endmodule

// File: rtl/angle_bcd_conv.sv
// Rate-limited signed-angle to sign+5-digit BCD converter feeding the
// seven-segment display driver; one-deep newest-wins input slot.
module angle_bcd_conv
  import angle_disp_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 5_000_000,
  parameter logic [3:0]  SIGN_NEG       = DEF_SIGN_NEG,
  parameter logic [3:0]  SIGN_BLANK     = DEF_SIGN_BLANK
) (
  input logic            clk_in,
  input logic            rst_n,
  angle_bcd_conv_if.slave bus
);

  localparam logic [31:0] REFRESH_LOAD = 32'(REFRESH_CYCLES - 1);

  conv_state_e      state_q, state_d;
  logic [15:0]      pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [31:0]      refresh_q, refresh_d;
  logic             sign_q, sign_d;
  logic [BIN_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      data_q, data_d;
  logic             data_vld_q, data_vld_d;
  logic             busy_q, busy_d;

  logic [BCD_W-1:0] bcd_step;
  logic [BIN_W-1:0] mag_step;
  logic             start;

  bcd_dabble_step u_step (
    .bcd_in  (bcd_q),
    .bin_in  (mag_q),
    .bcd_out (bcd_step),
    .bin_out (mag_step)
  );

  assign start = (state_q == ST_IDLE) && pend_vld_q && (refresh_q == 32'd0);

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    refresh_d  = (refresh_q != 32'd0) ? (refresh_q - 32'd1) : 32'd0;
    sign_d     = sign_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    data_vld_d = 1'b0;

    // Clear before write so a strobe coinciding with a start stays pending.
    if (start) begin
      pend_vld_d = 1'b0;
      refresh_d  = REFRESH_LOAD;
    end
    if (bus.angle_vld_in) begin
      pend_d     = bus.angle_in;
      pend_vld_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d    = pend_q[15];
          mag_d     = abs16(pend_q);
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        bcd_d     = bcd_step;
        mag_d     = mag_step;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'(CONV_ITERS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        data_d     = {sign_q ? SIGN_NEG : SIGN_BLANK, bcd_q};
        data_vld_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      refresh_q  <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      data_q     <= {SIGN_BLANK, 20'h00000};
      data_vld_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      refresh_q  <= refresh_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.data_vld_out = data_vld_q;
  assign bus.busy_out     = busy_q;

endmodule

// File: tb/tb_angle_bcd_conv.sv
// Directed bench for angle_bcd_conv: DUT A uses REFRESH_CYCLES=32, DUT B uses 1.
module tb_angle_bcd_conv;

  typedef struct {
    int          c;
    logic [23:0] d;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  ev_t  qa[$];
  ev_t  qb[$];

  angle_bcd_conv_if ifa ();
  angle_bcd_conv_if ifb ();

  angle_bcd_conv #(.REFRESH_CYCLES(32)) dut_a (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (ifa)
  );

  angle_bcd_conv #(.REFRESH_CYCLES(1)) dut_b (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc names the most recent rising edge; pulses are logged against it.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifa.data_vld_out) qa.push_back('{c: cyc, d: ifa.data_out});
    if (ifb.data_vld_out) qb.push_back('{c: cyc, d: ifb.data_out});
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobe is sampled at edge t; returns at the negedge following edge t.
  task automatic strobe(input bit sel, input logic [15:0] a, output int t);
    @(negedge clk);
    if (sel) begin
      ifb.angle_in = a;
      ifb.angle_vld_in = 1'b1;
    end else begin
      ifa.angle_in = a;
      ifa.angle_vld_in = 1'b1;
    end
    t = cyc + 1;
    @(negedge clk);
    ifa.angle_vld_in = 1'b0;
    ifb.angle_vld_in = 1'b0;
  endtask

  task automatic pop_ev(input bit sel, input string tag, input int exp_c, input logic [23:0] exp_d);
    ev_t e;
    int  sz;
    sz = sel ? qb.size() : qa.size();
    check_eq({tag, "_present"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      e = sel ? qb.pop_front() : qa.pop_front();
      check_eq({tag, "_cycle"}, 32'(e.c), 32'(exp_c));
      check_eq({tag, "_data"}, {8'h0, e.d}, {8'h0, exp_d});
      $display("%s: dut %0d pulse at cycle %0d data %h (want %0d / %h)",
               tag, sel, e.c, e.d, exp_c, exp_d);
    end
  endtask

  task automatic expect_none(input bit sel, input string tag);
    int sz;
    sz = sel ? qb.size() : qa.size();
    check_eq({tag, "_no_extra"}, 32'(sz), 32'd0);
    if (sel) qb.delete(); else qa.delete();
  endtask

  task automatic conv_a(input string tag, input logic [15:0] a, input logic [23:0] exp_d);
    int t;
    strobe(1'b0, a, t);
    idle(40);
    pop_ev(1'b0, tag, t + 18, exp_d);
    expect_none(1'b0, tag);
  endtask

  initial begin
    int t, t2, t3;
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    ifa.angle_in = '0;
    ifa.angle_vld_in = 1'b0;
    ifb.angle_in = '0;
    ifb.angle_vld_in = 1'b0;

    idle(3);
    check_eq("rst_data", {8'h0, ifa.data_out}, 32'h00F00000);
    check_eq("rst_vld", 32'(ifa.data_vld_out), 32'd0);
    check_eq("rst_busy", 32'(ifa.busy_out), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 1: cycle-accurate latency, busy window and output hold
    strobe(1'b0, 16'd90, t);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      check_eq($sformatf("s1_busy_%0d", k), 32'(ifa.busy_out), 32'(k <= 17));
      check_eq($sformatf("s1_vld_%0d", k), 32'(ifa.data_vld_out), 32'(k == 18));
      check_eq($sformatf("s1_data_%0d", k), {8'h0, ifa.data_out},
               (k >= 18) ? 32'h00F00090 : 32'h00F00000);
    end
    idle(25);
    pop_ev(1'b0, "s1_90", t + 18, 24'hF00090);
    expect_none(1'b0, "s1");

    // 2, 3: sign handling and range extremes
    conv_a("s2_m45", 16'hFFD3, 24'hA00045);
    conv_a("s2_zero", 16'h0000, 24'hF00000);
    conv_a("s3_min", 16'h8000, 24'hA32768);
    conv_a("s3_max", 16'h7FFF, 24'hF32767);

    // 5: second strobe right after a start waits for the refresh window
    strobe(1'b0, 16'd200, t);
    strobe(1'b0, 16'd123, t2);
    idle(60);
    pop_ev(1'b0, "s5_200", t + 18, 24'hF00200);
    pop_ev(1'b0, "s5_123", t + 50, 24'hF00123);
    expect_none(1'b0, "s5");

    // 4: REFRESH_CYCLES=1, newest pending sample wins while busy
    strobe(1'b1, 16'd10, t);
    idle(3);
    strobe(1'b1, 16'd20, t2);
    idle(3);
    strobe(1'b1, 16'd30, t3);
    idle(50);
    pop_ev(1'b1, "s4_10", t + 18, 24'hF00010);
    pop_ev(1'b1, "s4_30", t + 36, 24'hF00030);
    expect_none(1'b1, "s4");

    // 6: reset mid-conversion aborts without a pulse
    strobe(1'b0, 16'd77, t);
    idle(8);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("s6_rst_data", {8'h0, ifa.data_out}, 32'h00F00000);
    check_eq("s6_rst_busy", 32'(ifa.busy_out), 32'd0);
    check_eq("s6_rst_vld", 32'(ifa.data_vld_out), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(30);
    expect_none(1'b0, "s6_abort");
    conv_a("s6_5", 16'd5, 24'hF00005);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
